// File: rtl/hsv_core_fetch.sv
// Instruction fetch stage: sequential word reads from instruction memory,
// in-order response FIFO, and the fetch->decode ready/valid channel.
// Handles flush and redirect by discarding reads that are still in flight.

package hsv_core_fetch_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        fault;
    } fetch_data_t;

endpackage

module hsv_core_fetch
    import hsv_core_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        flush_req,
    output logic        flush_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error,
    input  logic        ready_i,
    output logic        valid_o,
    output fetch_data_t fetch_data
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // One spare bit so outstanding + fifo occupancy never overflows.
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    // Architectural state
    logic [31:0]   pc;          // next address to be placed on the request port
    logic [31:0]   resp_pc;     // PC tag for the next accepted response
    logic [31:0]   req_addr;
    logic          req_valid;
    logic [CW-1:0] outstanding; // reads accepted by memory, response not yet seen
    logic [CW-1:0] discard;     // responses still to be dropped as stale
    logic          halted;
    logic          flush_ack_q;

    fetch_data_t   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Next-state and handshake terms
    logic          fire;
    logic          hold;
    logic          pop;
    logic          restart;
    logic          drop;
    logic          push;
    logic          issue_ok;
    logic          raise;
    logic [31:0]   redirect_target;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] stale_next;
    logic [CW-1:0] count_next;
    logic [CW-1:0] discard_next;
    logic          halted_next;
    logic          req_valid_next;
    logic [31:0]   req_addr_next;
    logic [31:0]   pc_next;
    logic [31:0]   resp_pc_next;
    logic          flush_ack_next;
    fetch_data_t   wr_entry;

    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state computation for the request side, response side and FIFO occupancy
    always_comb begin
        fire            = req_valid & mem_req_ready;
        hold            = req_valid & ~mem_req_ready;
        pop             = (count != '0) & ready_i;
        restart         = redirect_valid | flush_req;
        redirect_target = {redirect_pc[31:2], 2'b00};

        // A response arriving during redirect/flush belongs to the old stream.
        drop = mem_rsp_valid & ((discard != '0) | restart);
        push = mem_rsp_valid & ~drop;

        outstanding_next = outstanding + CW'(fire) - CW'(mem_rsp_valid);
        // A request still waiting on the port will fire later with an old
        // address, so it is stale too and must be discarded when it returns.
        stale_next       = outstanding_next + CW'(hold);

        count_next = restart ? '0 : (count + CW'(push) - CW'(pop));

        halted_next = halted;
        if (redirect_valid) begin
            halted_next = 1'b0;
        end else if (push && mem_rsp_error) begin
            halted_next = 1'b1;
        end

        discard_next = discard;
        if (restart) begin
            discard_next = stale_next;
        end else if (push && mem_rsp_error) begin
            // Reads issued behind a faulting word never reach decode.
            discard_next = stale_next;
        end else if (drop) begin
            discard_next = discard - CW'(1);
        end

        issue_ok = ~flush_req & ~redirect_valid & ~halted_next
                 & (outstanding_next < CW'(MAX_OUTSTANDING))
                 & ((outstanding_next + count_next) < CW'(FIFO_DEPTH));

        // A raised request is held until accepted; a new one is loaded only
        // when the port is free (idle or firing this cycle).
        raise          = ~hold & issue_ok;
        req_valid_next = hold | issue_ok;
        req_addr_next  = raise ? pc : req_addr;

        // pc advances when an address is handed to the request port, so a
        // redirect never gets incremented by a fire of an older address.
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (raise) begin
            pc_next = pc + 32'd4;
        end else begin
            pc_next = pc;
        end

        if (redirect_valid) begin
            resp_pc_next = redirect_target;
        end else if (flush_req) begin
            resp_pc_next = pc_next;
        end else if (push) begin
            resp_pc_next = resp_pc + 32'd4;
        end else begin
            resp_pc_next = resp_pc;
        end

        flush_ack_next = flush_req & (outstanding_next == '0) & ~hold;

        wr_entry.insn  = mem_rsp_error ? 32'h0 : mem_rsp_data;
        wr_entry.pc    = resp_pc;
        wr_entry.fault = mem_rsp_error;
    end

    // Control and pointer registers with synchronous reset
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            req_addr    <= RESET_PC;
            req_valid   <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            halted      <= 1'b0;
            flush_ack_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            pc          <= pc_next;
            resp_pc     <= resp_pc_next;
            req_addr    <= req_addr_next;
            req_valid   <= req_valid_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            halted      <= halted_next;
            flush_ack_q <= flush_ack_next;
            count       <= count_next;
            if (restart) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are don't-care while count is zero
    always_ff @(posedge clk_core) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_entry;
        end
    end

    assign mem_req_valid = req_valid;
    assign mem_req_addr  = req_addr;
    assign flush_ack     = flush_ack_q;
    assign valid_o       = (count != '0);
    assign fetch_data    = fifo_mem[rd_ptr];

    // The credit rule reserves a slot per read, so a push into a full FIFO is a bug.
    a_no_overflow: assert property (@(posedge clk_core) disable iff (rst_core)
        !(push && (count == CW'(FIFO_DEPTH)) && !pop));

    // Memory must not return more responses than reads it accepted.
    a_rsp_has_read: assert property (@(posedge clk_core) disable iff (rst_core)
        !(mem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_hsv_core_fetch.sv
// Self-checking bench for hsv_core_fetch: in-order memory model with random
// latency/back-pressure, expected program-order stream per fetch segment,
// and a monitor that pops and compares on every decode handshake.

module tb_hsv_core_fetch;
    import hsv_core_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] NO_ERR   = 32'h0000_0002;   // unaligned, never requested

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b1;
    logic        flush_req = 1'b0;
    logic        flush_ack;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        mem_rsp_error = 1'b0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    fetch_data_t fetch_data;

    always #5 clk_core = ~clk_core;

    hsv_core_fetch #(
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(4),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_core(clk_core),
        .rst_core(rst_core),
        .flush_req(flush_req),
        .flush_ack(flush_ack),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .mem_rsp_error(mem_rsp_error),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .fetch_data(fetch_data)
    );

    typedef struct {
        logic [31:0] addr;
        longint      due;
    } rd_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    fetch_data_t exp_q[$];
    int          seg_cnt = 0;
    logic [31:0] err_addr = NO_ERR;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;
    int          rdy_mode = 1;           // 0: decode stalls, 1: always ready, 2: random
    rd_t         inflight[$];
    logic [31:0] fire_q[$];
    longint      cyc = 0;
    longint      last_rsp_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected decode stream from a start address: consecutive words, ending at a faulting word.
    task automatic seg_start(input logic [31:0] start);
        logic [31:0] a;
        fetch_data_t e;
        exp_q.delete();
        seg_cnt = 0;
        a = {start[31:2], 2'b00};
        for (int i = 0; i < 256; i++) begin
            e.pc    = a;
            e.fault = (a == err_addr);
            e.insn  = e.fault ? 32'h0 : mem_word(a);
            exp_q.push_back(e);
            if (e.fault) break;
            a = a + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #2;
    endtask

    task automatic do_reset();
        rst_core = 1'b1;
        redirect_valid = 1'b0;
        flush_req = 1'b0;
        @(posedge clk_core);
        seg_start(RESET_PC);
        #2;
        rst_core = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target, input bit with_flush);
        redirect_valid = 1'b1;
        redirect_pc = target;
        if (with_flush) flush_req = 1'b1;
        @(posedge clk_core);
        seg_start(target);
        #2;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_fire(output logic [31:0] a, output bit ok);
        ok = 1'b0;
        a = 32'hDEAD_BEEF;
        for (int i = 0; i < 60; i++) begin
            if (fire_q.size() > 0) begin
                a = fire_q.pop_front();
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Memory: accepts requests, returns them in order after a random latency.
    initial begin
        rd_t r;
        forever begin
            @(posedge clk_core);
            cyc++;
            #1;
            if (inflight.size() > 0 && inflight[0].due <= cyc) begin
                r = inflight.pop_front();
                mem_rsp_valid = 1'b1;
                mem_rsp_error = (r.addr == err_addr);
                mem_rsp_data  = mem_rsp_error ? $urandom : mem_word(r.addr);
                last_rsp_cyc  = cyc;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_error = 1'b0;
                mem_rsp_data  = $urandom;
            end
            mem_req_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk_core);
            if (rst_core) begin
                inflight.delete();
            end else if (mem_req_valid && mem_req_ready) begin
                r.addr = mem_req_addr;
                r.due  = cyc + longint'($urandom_range(lat_max, lat_min));
                inflight.push_back(r);
                fire_q.push_back(mem_req_addr);
            end
        end
    end

    // Decode back-pressure
    initial begin
        forever begin
            @(posedge clk_core);
            #1;
            case (rdy_mode)
                0:       ready_i = 1'b0;
                1:       ready_i = 1'b1;
                default: ready_i = 1'($urandom_range(1));
            endcase
        end
    end

    // Monitor: every accepted entry must be the next word of the current stream.
    initial begin
        fetch_data_t e;
        forever begin
            @(negedge clk_core);
            if (!rst_core && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got pc %h insn %h fault %b, required no entry",
                             fetch_data.pc, fetch_data.insn, fetch_data.fault);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_entry", 65'(fetch_data), 65'(e));
                    seg_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no end of run, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] e_addr;
        bit          ok;
        int          k;
        int          vbad;
        longint      ack_cyc;

        repeat (3) @(posedge clk_core);
        #2;

        // Reset state, then credit limit with decode stalled
        rdy_mode = 0; lat_min = 1; lat_max = 1; rdy_pct = 100;
        do_reset();
        fire_q.delete();
        @(negedge clk_core);
        check("reset_valid_o", 65'(valid_o), 65'(0));
        check("reset_mem_req_valid", 65'(mem_req_valid), 65'(0));
        check("reset_flush_ack", 65'(flush_ack), 65'(0));
        repeat (20) tick();
        check("credit_fire_count", 65'(fire_q.size()), 65'(4));
        for (int i = 0; i < 4; i++) begin
            a = (fire_q.size() > 0) ? fire_q.pop_front() : 32'hDEAD_BEEF;
            check("credit_fire_addr", 65'(a), 65'(RESET_PC + 32'(4 * i)));
        end
        @(negedge clk_core);
        check("credit_req_stays_low", 65'(mem_req_valid), 65'(0));

        // Release decode: sequential stream from RESET_PC at full rate
        rdy_mode = 1;
        repeat (30) tick();
        check("stream_progress", 65'(seg_cnt >= 20), 65'(1));

        // Flush + redirect with reads in flight
        lat_min = 8; lat_max = 8;
        k = 0;
        while (inflight.size() < 3 && k < 30) begin tick(); k++; end
        check("flush_reads_in_flight", 65'(inflight.size() >= 3), 65'(1));
        do_redirect(32'h0000_2000, 1'b1);
        vbad = 0;
        ok = 1'b0;
        ack_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_core);
            if (valid_o) vbad++;
            if (flush_ack) begin ok = 1'b1; ack_cyc = cyc; break; end
            tick();
        end
        check("flush_valid_o_low", 65'(vbad), 65'(0));
        check("flush_ack_seen", 65'(ok), 65'(1));
        check("flush_ack_timing", 65'(ack_cyc), 65'(last_rsp_cyc + 1));
        lat_min = 1; lat_max = 1;
        fire_q.delete();
        tick();
        flush_req = 1'b0;
        @(negedge clk_core);
        check("flush_ack_held", 65'(flush_ack), 65'(1));
        tick();
        @(negedge clk_core);
        check("flush_ack_dropped", 65'(flush_ack), 65'(0));
        check("resume_req_valid", 65'(mem_req_valid), 65'(1));
        check("resume_req_addr", 65'(mem_req_addr), 65'(32'h0000_2000));
        repeat (10) tick();
        check("post_flush_progress", 65'(seg_cnt >= 3), 65'(1));

        // Access fault halts fetch until redirect
        err_addr = RESET_PC + 32'h8;
        do_reset();
        repeat (30) tick();
        check("fault_entry_count", 65'(seg_cnt), 65'(3));
        check("fault_stream_done", 65'(exp_q.size()), 65'(0));
        fire_q.delete();
        repeat (10) tick();
        check("halted_no_requests", 65'(fire_q.size()), 65'(0));
        err_addr = NO_ERR;
        do_redirect(32'h0000_4000, 1'b0);
        fire_q.delete();
        wait_fire(a, ok);
        check("halt_redirect_addr", 65'({ok, a}), 65'({1'b1, 32'h0000_4000}));
        repeat (10) tick();
        check("halt_redirect_progress", 65'(seg_cnt >= 3), 65'(1));

        // Unaligned redirect coincident with a request fire
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid && mem_req_ready) begin ok = 1'b1; break; end
            tick();
        end
        check("redirect_on_fire_seen", 65'(ok), 65'(1));
        do_redirect(32'h0000_3002, 1'b0);
        fire_q.delete();
        wait_fire(a, ok);
        check("redirect_aligned_addr", 65'({ok, a}), 65'({1'b1, 32'h0000_3000}));
        repeat (12) tick();
        check("redirect_progress", 65'(seg_cnt >= 3), 65'(1));

        // Reset mid-stream with a full FIFO
        rdy_mode = 0;
        repeat (15) tick();
        @(negedge clk_core);
        check("full_before_reset", 65'(valid_o), 65'(1));
        tick();
        do_reset();
        @(negedge clk_core);
        check("midreset_valid_o", 65'(valid_o), 65'(0));
        check("midreset_mem_req_valid", 65'(mem_req_valid), 65'(0));
        rdy_mode = 1;
        fire_q.delete();
        wait_fire(a, ok);
        check("midreset_restart_addr", 65'({ok, a}), 65'({1'b1, RESET_PC}));
        repeat (12) tick();
        check("midreset_progress", 65'(seg_cnt >= 3), 65'(1));

        // Random segments: redirects (some with flush), latency, back-pressure, faults, wrap
        for (int s = 0; s < 14; s++) begin
            lat_min  = 1;
            lat_max  = $urandom_range(4, 1);
            rdy_pct  = $urandom_range(100, 40);
            rdy_mode = 2;
            a = $urandom;
            if (s % 4 == 3) a = 32'hFFFF_FFF0 | (a & 32'h3);
            e_addr = {a[31:2], 2'b00} + 32'(4 * $urandom_range(6, 1));
            err_addr = ($urandom_range(2) == 0) ? e_addr : NO_ERR;
            do_redirect(a, 1'($urandom_range(1)));
            if (flush_req) begin
                k = 0;
                while (!flush_ack && k < 60) begin tick(); k++; end
                check("rand_flush_ack", 65'(flush_ack), 65'(1));
                flush_req = 1'b0;
            end
            repeat ($urandom_range(80, 40)) tick();
            check("rand_segment_progress", 65'(seg_cnt > 0), 65'(1));
        end

        rdy_mode = 1;
        repeat (10) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
